// File: rtl/ws2812_pkg.sv
// -----------------------------------------------------------------------------
// ws2812_pkg
// Shared WS2812 timing constants (in 50 MHz clock cycles) and the receiver FSM
// state type. Used by both the transmitter and the receiver so the two sides
// agree on pulse widths and the latch gap.
// -----------------------------------------------------------------------------
package ws2812_pkg;

  localparam int WS_T0H        = 20;    // '0' high time
  localparam int WS_T1H        = 40;    // '1' high time
  localparam int WS_T_BIT      = 62;    // full bit period
  localparam int WS_RESET_LOW  = 2500;  // latch gap (50 us)
  localparam int WS_BIT_THRESH = 30;    // high >= this decodes as '1'
  localparam int WS_MIN_HIGH   = 5;     // shorter high is a glitch
  localparam int WS_MAX_HIGH   = 60;    // high reaching this is stuck/overlong
  localparam int WS_PIX_W      = 16;    // pixel index / count width
  localparam int WS_WORD_W     = 24;    // GRB word width

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,  // waiting for a clean latch gap before arming
    S_IDLE = 2'd1,  // armed, line low, no bit in progress
    S_HIGH = 2'd2,  // measuring a high pulse
    S_LOW  = 2'd3   // measuring the low gap after a bit
  } ws2812_state_e;

  // Completes a word: the 23 bits gathered so far followed by the newest bit.
  function automatic logic [WS_WORD_W-1:0] ws2812_word(input logic [WS_WORD_W-2:0] partial,
                                                       input logic newest);
    return {partial, newest};
  endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// -----------------------------------------------------------------------------
// ws2812_rx_if
// Output bundle of the WS2812 receiver.
//   pixel_data   [23:0]   received word {G,R,B}, first bit on the line = bit 23
//   pixel_valid           one-cycle strobe for pixel_data / pixel_idx
//   pixel_idx    [PIX_W]  index of the pixel within the current frame
//   frame_done            one-cycle strobe at the latch gap
//   frame_pixels [PIX_W]  completed pixels in the frame, valid with frame_done
//   err                   one-cycle strobe on any protocol violation
// master: the receiver drives the bundle; slave: a consumer observes it.
// -----------------------------------------------------------------------------
interface ws2812_rx_if #(
  parameter int PIX_W = 16
);
  logic [23:0]      pixel_data;
  logic             pixel_valid;
  logic [PIX_W-1:0] pixel_idx;
  logic             frame_done;
  logic [PIX_W-1:0] frame_pixels;
  logic             err;

  modport master (
    output pixel_data, pixel_valid, pixel_idx, frame_done, frame_pixels, err
  );

  modport slave (
    input pixel_data, pixel_valid, pixel_idx, frame_done, frame_pixels, err
  );
endinterface

// File: rtl/ws2812_edge_sync.sv
// -----------------------------------------------------------------------------
// ws2812_edge_sync
// Two-flop synchronizer for the asynchronous WS2812 line with registered
// rise/fall strobes. The strobes assert in the same cycle the synchronized
// level first shows the new value.
//   clk, rst_n  clock, asynchronous active-low reset
//   din         raw serial line
//   level       synchronized line value
//   rise, fall  one-cycle edge strobes aligned with level
// -----------------------------------------------------------------------------
module ws2812_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Next-state for the synchronizer chain and edge strobes.
  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    // s1 holds the value s2 is about to take, so compare them to flag the edge
    // in the same cycle s2 changes.
    rise_d = s1_q & ~s2_q;
    fall_d = ~s1_q & s2_q;
  end

  // Synchronizer and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = s2_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ws2812_rx.sv
// -----------------------------------------------------------------------------
// ws2812_rx
// WS2812 receive decoder. Classifies each bit by its high-pulse width,
// assembles 24-bit GRB words and reports frame end at the latch gap.
//   clk         50 MHz system clock
//   rst_n       asynchronous active-low reset
//   ws2812_din  asynchronous serial line
//   rx          ws2812_rx_if.master: pixel_data/valid/idx, frame_done,
//               frame_pixels, err (all registered)
// -----------------------------------------------------------------------------
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int BIT_THRESH = WS_BIT_THRESH,
  parameter int MIN_HIGH   = WS_MIN_HIGH,
  parameter int MAX_HIGH   = WS_MAX_HIGH,
  parameter int RESET_LOW  = WS_RESET_LOW,
  parameter int PIX_W      = WS_PIX_W
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     ws2812_din,
  ws2812_rx_if.master rx
);

  localparam int LCNT_W = $clog2(RESET_LOW + 1);
  localparam int HCNT_W = $clog2(MAX_HIGH + 1);

  // The "_LAST" values are one short of the limit: the limit is reached on the
  // cycle that would increment past them.
  localparam logic [LCNT_W-1:0] LOW_LAST    = LCNT_W'(RESET_LOW - 1);
  localparam logic [LCNT_W-1:0] LOW_MAX     = LCNT_W'(RESET_LOW);
  localparam logic [HCNT_W-1:0] HIGH_LAST   = HCNT_W'(MAX_HIGH - 1);
  localparam logic [HCNT_W-1:0] HIGH_MAX    = HCNT_W'(MAX_HIGH);
  localparam logic [HCNT_W-1:0] HIGH_THRESH = HCNT_W'(BIT_THRESH);
  localparam logic [HCNT_W-1:0] HIGH_MIN    = HCNT_W'(MIN_HIGH);

  logic din_s, rise_s, fall_s;
  logic bit_s;

  ws2812_state_e        state_q, state_d;
  logic [LCNT_W-1:0]    lcnt_q, lcnt_d;
  logic [HCNT_W-1:0]    hcnt_q, hcnt_d;
  logic [22:0]          shift_q, shift_d;
  logic [4:0]           bitcnt_q, bitcnt_d;
  logic [PIX_W-1:0]     idx_q, idx_d;
  logic [23:0]          pixel_data_q, pixel_data_d;
  logic                 pixel_valid_q, pixel_valid_d;
  logic [PIX_W-1:0]     pixel_idx_q, pixel_idx_d;
  logic                 frame_done_q, frame_done_d;
  logic [PIX_W-1:0]     frame_pixels_q, frame_pixels_d;
  logic                 err_q, err_d;

  ws2812_edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ws2812_din),
    .level (din_s),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  // FSM next-state, pulse counters, bit assembly and output strobes.
  always_comb begin
    state_d        = state_q;
    lcnt_d         = lcnt_q;
    hcnt_d         = hcnt_q;
    shift_d        = shift_q;
    bitcnt_d       = bitcnt_q;
    idx_d          = idx_q;
    pixel_data_d   = pixel_data_q;
    pixel_valid_d  = 1'b0;
    pixel_idx_d    = pixel_idx_q;
    frame_done_d   = 1'b0;
    frame_pixels_d = frame_pixels_q;
    err_d          = 1'b0;
    bit_s          = 1'b0;

    case (state_q)
      S_SYNC: begin
        // Any high restarts the gap; a full gap arms a fresh frame at index 0.
        if (din_s) begin
          lcnt_d = '0;
        end else if (lcnt_q >= LOW_LAST) begin
          lcnt_d   = LOW_MAX;
          state_d  = S_IDLE;
          idx_d    = '0;
          bitcnt_d = 5'd0;
        end else begin
          lcnt_d = lcnt_q + LCNT_W'(1);
        end
      end

      S_IDLE: begin
        if (rise_s) begin
          state_d = S_HIGH;
          hcnt_d  = HCNT_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end

      S_HIGH: begin
        if (fall_s) begin
          if (hcnt_q < HIGH_MIN) begin
            err_d    = 1'b1;
            state_d  = S_SYNC;
            lcnt_d   = '0;
            bitcnt_d = 5'd0;
          end else begin
            bit_s   = (hcnt_q >= HIGH_THRESH);
            shift_d = {shift_q[21:0], bit_s};
            state_d = S_LOW;
            lcnt_d  = LCNT_W'(1);
            if (bitcnt_q == 5'd23) begin
              pixel_data_d  = ws2812_word(shift_q, bit_s);
              pixel_valid_d = 1'b1;
              pixel_idx_d   = idx_q;
              idx_d         = idx_q + PIX_W'(1);
              bitcnt_d      = 5'd0;
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end else if (hcnt_q >= HIGH_LAST) begin
          // Still high as the count reaches MAX_HIGH: stuck or overlong line.
          hcnt_d   = HIGH_MAX;
          err_d    = 1'b1;
          state_d  = S_SYNC;
          lcnt_d   = '0;
          bitcnt_d = 5'd0;
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end

      S_LOW: begin
        if (rise_s) begin
          state_d = S_HIGH;
          hcnt_d  = HCNT_W'(1);
        end else if (lcnt_q >= LOW_LAST) begin
          // Latch gap: close the frame; a partial pixel is dropped and flagged.
          lcnt_d         = LOW_MAX;
          state_d        = S_IDLE;
          frame_done_d   = 1'b1;
          frame_pixels_d = idx_q;
          idx_d          = '0;
          err_d          = (bitcnt_q != 5'd0);
          bitcnt_d       = 5'd0;
        end else begin
          lcnt_d = lcnt_q + LCNT_W'(1);
        end
      end

      default: begin
        state_d  = S_SYNC;
        lcnt_d   = '0;
        bitcnt_d = 5'd0;
      end
    endcase
  end

  // State, counter, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_SYNC;
      lcnt_q         <= '0;
      hcnt_q         <= '0;
      shift_q        <= '0;
      bitcnt_q       <= 5'd0;
      idx_q          <= '0;
      pixel_data_q   <= 24'h000000;
      pixel_valid_q  <= 1'b0;
      pixel_idx_q    <= '0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      lcnt_q         <= lcnt_d;
      hcnt_q         <= hcnt_d;
      shift_q        <= shift_d;
      bitcnt_q       <= bitcnt_d;
      idx_q          <= idx_d;
      pixel_data_q   <= pixel_data_d;
      pixel_valid_q  <= pixel_valid_d;
      pixel_idx_q    <= pixel_idx_d;
      frame_done_q   <= frame_done_d;
      frame_pixels_q <= frame_pixels_d;
      err_q          <= err_d;
    end
  end

  assign rx.pixel_data   = pixel_data_q;
  assign rx.pixel_valid  = pixel_valid_q;
  assign rx.pixel_idx    = pixel_idx_q;
  assign rx.frame_done   = frame_done_q;
  assign rx.frame_pixels = frame_pixels_q;
  assign rx.err          = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// -----------------------------------------------------------------------------
// tb_ws2812_rx
// Drives WS2812 waveforms into ws2812_rx and compares the observed strobes
// against an event-level model of the protocol: every valid bit appends to a
// word, every 24 bits yield a pixel 3 cycles after that bit's falling edge,
// a latch gap closes the frame RESET_LOW+2 cycles after the last fall.
// -----------------------------------------------------------------------------
module tb_ws2812_rx;
  import ws2812_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic din;

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int last_fall = 0;

  ws2812_rx_if #(.PIX_W(WS_PIX_W)) rx_if ();

  ws2812_rx #(.PIX_W(WS_PIX_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ws2812_din (din),
    .rx         (rx_if)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events.
  int          ob_pv_cyc[$];
  logic [23:0] ob_pv_data[$];
  int          ob_pv_idx[$];
  int          ob_fd_cyc[$];
  int          ob_fd_pix[$];
  int          ob_err_cyc[$];

  // Expected events from the model.
  int          ex_pv_cyc[$];
  logic [23:0] ex_pv_data[$];
  int          ex_pv_idx[$];
  int          ex_fd_cyc[$];
  int          ex_fd_pix[$];
  int          ex_err_cyc[$];

  int          m_idx  = 0;
  int          m_bits = 0;
  logic [23:0] m_word = 24'h0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_if.pixel_valid) begin
        ob_pv_cyc.push_back(cyc);
        ob_pv_data.push_back(rx_if.pixel_data);
        ob_pv_idx.push_back(int'(rx_if.pixel_idx));
      end
      if (rx_if.frame_done) begin
        ob_fd_cyc.push_back(cyc);
        ob_fd_pix.push_back(int'(rx_if.frame_pixels));
      end
      if (rx_if.err) ob_err_cyc.push_back(cyc);
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---- model ---------------------------------------------------------------
  task automatic model_bit(input logic b);
    m_word = {m_word[22:0], b};
    m_bits++;
    if (m_bits == 24) begin
      ex_pv_cyc.push_back(last_fall + 3);
      ex_pv_data.push_back(m_word);
      ex_pv_idx.push_back(m_idx);
      m_idx  = (m_idx + 1) % 65536;
      m_bits = 0;
    end
  endtask

  task automatic model_latch();
    ex_fd_cyc.push_back(last_fall + WS_RESET_LOW + 2);
    ex_fd_pix.push_back(m_idx);
    if (m_bits != 0) ex_err_cyc.push_back(last_fall + WS_RESET_LOW + 2);
    m_idx  = 0;
    m_bits = 0;
  endtask

  task automatic model_abort(input int err_at);
    ex_err_cyc.push_back(err_at);
    m_idx  = 0;  // the next frame after re-arm starts at index 0
    m_bits = 0;
  endtask

  // ---- line driver ---------------------------------------------------------
  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pulse(input int hi, input int lo);
    drive(1'b1, hi);
    last_fall = cyc;
    drive(1'b0, lo);
  endtask

  task automatic send_bit_w(input logic b, input int hi, input int lo);
    send_pulse(hi, lo);
    model_bit(b);
  endtask

  task automatic send_bit_r(input logic b);
    int hi;
    hi = b ? int'($urandom_range(59, 30)) : int'($urandom_range(29, 5));
    send_bit_w(b, hi, int'($urandom_range(40, 3)));
  endtask

  task automatic send_word_w(input logic [23:0] w, input int hi0, input int hi1, input int lo_last);
    for (int i = 23; i >= 0; i--) begin
      int hi;
      hi = w[i] ? hi1 : hi0;
      send_bit_w(w[i], hi, (i == 0) ? lo_last : (WS_T_BIT - hi));
    end
  endtask

  task automatic latch();
    model_latch();
    drive(1'b0, WS_RESET_LOW + 20);
  endtask

  task automatic compare_events(input string tag);
    chk_eq({tag, ".pv_n"}, ob_pv_cyc.size(), ex_pv_cyc.size());
    for (int i = 0; i < ob_pv_cyc.size() && i < ex_pv_cyc.size(); i++) begin
      chk_eq({tag, ".pv_cyc"},  ob_pv_cyc[i],  ex_pv_cyc[i]);
      chk_eq({tag, ".pv_data"}, ob_pv_data[i], ex_pv_data[i]);
      chk_eq({tag, ".pv_idx"},  ob_pv_idx[i],  ex_pv_idx[i]);
    end
    chk_eq({tag, ".fd_n"}, ob_fd_cyc.size(), ex_fd_cyc.size());
    for (int i = 0; i < ob_fd_cyc.size() && i < ex_fd_cyc.size(); i++) begin
      chk_eq({tag, ".fd_cyc"}, ob_fd_cyc[i], ex_fd_cyc[i]);
      chk_eq({tag, ".fd_pix"}, ob_fd_pix[i], ex_fd_pix[i]);
    end
    chk_eq({tag, ".err_n"}, ob_err_cyc.size(), ex_err_cyc.size());
    for (int i = 0; i < ob_err_cyc.size() && i < ex_err_cyc.size(); i++) begin
      chk_eq({tag, ".err_cyc"}, ob_err_cyc[i], ex_err_cyc[i]);
    end
    ob_pv_cyc.delete();  ob_pv_data.delete(); ob_pv_idx.delete();
    ob_fd_cyc.delete();  ob_fd_pix.delete();  ob_err_cyc.delete();
    ex_pv_cyc.delete();  ex_pv_data.delete(); ex_pv_idx.delete();
    ex_fd_cyc.delete();  ex_fd_pix.delete();  ex_err_cyc.delete();
  endtask

  task automatic random_frame();
    int          np;
    logic [23:0] w;
    np = int'($urandom_range(3, 1));
    for (int p = 0; p < np; p++) begin
      w = 24'($urandom);
      for (int i = 23; i >= 0; i--) send_bit_r(w[i]);
    end
    latch();
  endtask

  initial begin
    int h_start;
    din   = 1'b0;
    rst_n = 1'b0;

    // 1. reset state, then a full low gap arms the receiver silently
    repeat (3) @(negedge clk);
    chk_eq("rst.pixel_data",   rx_if.pixel_data,   24'h000000);
    chk_eq("rst.pixel_valid",  rx_if.pixel_valid,  1'b0);
    chk_eq("rst.pixel_idx",    rx_if.pixel_idx,    16'h0000);
    chk_eq("rst.frame_done",   rx_if.frame_done,   1'b0);
    chk_eq("rst.frame_pixels", rx_if.frame_pixels, 16'h0000);
    chk_eq("rst.err",          rx_if.err,          1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, WS_RESET_LOW + 20);
    compare_events("t1");
    chk_eq("t1.pixel_data", rx_if.pixel_data, 24'h000000);

    // 2. nominal single pixel
    send_word_w(24'hA53C0F, WS_T0H, WS_T1H, WS_T_BIT - WS_T1H);
    latch();
    compare_events("t2");
    chk_eq("t2.data_hold", rx_if.pixel_data, 24'hA53C0F);

    // 3. three pixels at width boundaries, 2499-cycle gap must not latch
    send_word_w(24'h000000, WS_MIN_HIGH, WS_MAX_HIGH - 1, WS_RESET_LOW - 1);
    send_word_w(24'hFFFFFF, WS_MIN_HIGH, WS_MAX_HIGH - 1, 10);
    send_word_w(24'h123456, WS_BIT_THRESH - 1, WS_BIT_THRESH, 20);
    latch();
    compare_events("t3");

    // 4. short glitch mid-pixel aborts; next frame restarts at index 0
    for (int i = 0; i < 10; i++) send_bit_r(1'($urandom));
    send_pulse(3, WS_RESET_LOW + 20);
    model_abort(last_fall + 3);
    send_word_w(24'h5AC381, WS_T0H, WS_T1H, WS_T_BIT - WS_T1H);
    latch();
    compare_events("t4");

    // 5. stuck-high line
    h_start = cyc;
    drive(1'b1, 100);
    model_abort(h_start + WS_MAX_HIGH + 2);
    drive(1'b0, WS_RESET_LOW + 20);
    compare_events("t5");

    // 6. partial pixel at the latch gap
    for (int i = 0; i < 12; i++) send_bit_r(1'($urandom));
    latch();
    compare_events("t6");

    // 7. random multi-frame traffic
    for (int f = 0; f < 3; f++) begin
      random_frame();
      compare_events("t7");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
